// File: rtl/uart_pkg.sv
// Shared types and constants for the UART receive-side FIFO controller.
package uart_pkg;

  localparam int TOUT_CHARS = 4;
  localparam int OVERSAMPLE = 16;

  typedef enum logic [1:0] {
    TRIG_1  = 2'b00,
    TRIG_4  = 2'b01,
    TRIG_8  = 2'b10,
    TRIG_14 = 2'b11
  } trig_sel_t;

  typedef struct packed {
    logic brk;
    logic fe;
    logic pe;
  } rx_err_t;

  // rda_irq asserts when occupancy strictly exceeds this value.
  function automatic logic [3:0] trig_threshold(input trig_sel_t sel);
    case (sel)
      TRIG_1:  return 4'd0;
      TRIG_4:  return 4'd3;
      TRIG_8:  return 4'd7;
      default: return 4'd13;
    endcase
  endfunction

endpackage

// File: rtl/uart_sync_fifo.sv
// Synchronous show-ahead FIFO; full/empty derive from the occupancy count.
module uart_sync_fifo #(
  parameter int DEPTH = 16,
  parameter int W     = 11
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     clr,
  input  logic                     push,
  input  logic [W-1:0]             wdata,
  input  logic                     pop,
  output logic [W-1:0]             rdata,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     empty,
  output logic                     full,
  output logic                     push_acc,
  output logic                     pop_acc
);

  localparam int AW = $clog2(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;

  assign empty = (count == '0);
  assign full  = (count == ($clog2(DEPTH)+1)'(DEPTH));

  // A full FIFO still accepts a push when a pop frees a slot in the same cycle.
  assign pop_acc  = pop && !empty && !clr;
  assign push_acc = push && !clr && (!full || pop_acc);

  assign rdata = empty ? '0 : mem[rd_ptr];

  // NOTE: storage has no reset; entries are only visible once count covers them.
  always_ff @(posedge clk) begin
    if (push_acc) mem[wr_ptr] <= wdata;
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of block ordering.
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_acc) wr_ptr <= wr_ptr + 1'b1;
      if (pop_acc)  rd_ptr <= rd_ptr + 1'b1;
      case ({push_acc, pop_acc})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/uart_rx_fifo_ctrl.sv
// UART receive FIFO with trigger-level, character-timeout, overrun and
// error-in-FIFO interrupt sources for the register block.
module uart_rx_fifo_ctrl
  import uart_pkg::*;
#(
  parameter int DEPTH  = 16,
  parameter int DATA_W = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     baud_tick,
  input  logic [3:0]               char_bits,
  input  logic [1:0]               trig_sel,
  input  logic                     fifo_clr,
  input  logic                     push,
  input  logic [DATA_W-1:0]        push_data,
  input  logic [2:0]               push_err,
  input  logic                     pop,
  output logic [DATA_W-1:0]        rd_data,
  output logic [2:0]               rd_err,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     empty,
  output logic                     full,
  output logic                     rda_irq,
  output logic                     timeout_irq,
  output logic                     overrun,
  output logic                     err_in_fifo
);

  localparam int CW = $clog2(DEPTH) + 1;
  localparam logic [9:0] TOUT_SCALE = 10'(TOUT_CHARS * OVERSAMPLE);

  logic          push_acc;
  logic          pop_acc;
  logic [CW-1:0] err_cnt;
  logic [9:0]    tout_cnt;
  logic [9:0]    tout_limit;

  uart_sync_fifo #(
    .DEPTH (DEPTH),
    .W     (DATA_W + 3)
  ) u_fifo (
    .clk      (clk),
    .rst      (rst),
    .clr      (fifo_clr),
    .push     (push),
    .wdata    ({push_err, push_data}),
    .pop      (pop),
    .rdata    ({rd_err, rd_data}),
    .count    (count),
    .empty    (empty),
    .full     (full),
    .push_acc (push_acc),
    .pop_acc  (pop_acc)
  );

  assign rda_irq = (count > CW'(trig_threshold(trig_sel_t'(trig_sel))));

  // Four character times measured in oversample ticks.
  assign tout_limit  = TOUT_SCALE * {6'd0, char_bits};
  assign timeout_irq = !empty && (tout_cnt == tout_limit);

  always_ff @(posedge clk) begin
    if (rst || fifo_clr || push_acc || pop_acc || empty) begin
      tout_cnt <= '0;
    end else if (baud_tick && (tout_cnt < tout_limit)) begin
      tout_cnt <= tout_cnt + 1'b1;
    end
  end

  // Tracks how many stored entries carry an error so the LSR bit is O(1).
  always_ff @(posedge clk) begin
    if (rst || fifo_clr) begin
      err_cnt <= '0;
    end else begin
      case ({push_acc && (push_err != 3'b000), pop_acc && (rd_err != 3'b000)})
        2'b10:   err_cnt <= err_cnt + 1'b1;
        2'b01:   err_cnt <= err_cnt - 1'b1;
        default: err_cnt <= err_cnt;
      endcase
    end
  end

  assign err_in_fifo = (err_cnt != '0);

  // Overrun is flagged the cycle after a push is refused by a full FIFO.
  always_ff @(posedge clk) begin
    if (rst) overrun <= 1'b0;
    else     overrun <= push && !fifo_clr && !push_acc;
  end

endmodule

// File: doc/uart_rx_fifo_ctrl.md
Name: uart_rx_fifo_ctrl

Overview:
- Receive-side FIFO and interrupt-source controller of the UART DUT; sits between the RX deserializer and the register block (RBR/LSR/IIR).
- Buffers received characters with their per-character error flags.
- Raises the receive-data-available interrupt at the FCR-selected trigger level and the character-timeout indication.
- Reports overrun and the LSR "error in FIFO" bit.

Parameters:
- DEPTH, 16, FIFO entries; power of two, ≥ 16.
- DATA_W, 8, character width.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- baud_tick  in  1  16x-oversample strobe, one clk wide
- char_bits  in  4  total frame bits per character (7..12), from LCR decode
- trig_sel  in  2  FCR[7:6] trigger-level select
- fifo_clr  in  1  FCR[1] pulse; flushes the FIFO
- push  in  1  RX deserializer delivers a character
- push_data  in  DATA_W  received character
- push_err  in  3  {break, framing, parity} for that character
- pop  in  1  RBR read strobe
- rd_data  out  DATA_W  head character (show-ahead)
- rd_err  out  3  head error flags
- count  out  $clog2(DEPTH)+1  current occupancy
- empty  out  1  count == 0
- full  out  1  count == DEPTH
- rda_irq  out  1  count > threshold(trig_sel)
- timeout_irq  out  1  character-timeout condition
- overrun  out  1  one-cycle pulse: push rejected because FIFO full
- err_in_fifo  out  1  at least one stored entry has a nonzero error field

Behaviour:
- Reset (rst=1 at posedge): pointers=0, count=0, empty=1, full=0, rda_irq=0, timeout_irq=0, overrun=0, err_in_fifo=0, timeout counter=0.
  - rd_data/rd_err=0 while empty.
  - Reset mid-operation discards all contents.
- Priority each cycle: rst > fifo_clr > push/pop.
  - fifo_clr behaves like reset for the FIFO state. A push or pop in the same cycle as fifo_clr is ignored.
- Push: with !full, write {push_err, push_data} at wr_ptr; wr_ptr++ (mod DEPTH); count++ next cycle.
- Push while full:
  - If pop is also high, both occur; count unchanged, no overrun.
  - Otherwise the data is dropped, overrun=1 for exactly one cycle, and contents are unchanged.
- Pop: with !empty, rd_ptr++; count-- next cycle. Pop while empty is ignored, with no state change.
- Simultaneous push and pop while empty: push accepted, pop ignored, count becomes 1.
- Read path: rd_data/rd_err are combinational from the head entry (zero latency). They are valid whenever !empty.
- Thresholds from trig_sel: 00→0, 01→3, 10→7, 11→13. rda_irq = (count > threshold), so the interrupt fires at 1/4/8/14 characters.
  - rda_irq is combinational from registered count; trig_sel changes take effect immediately.
- err_in_fifo:
  - An internal error-entry counter increments on an accepted push with push_err≠0.
  - It decrements on a pop whose head rd_err≠0.
  - On a simultaneous push and pop, both adjustments apply.
  - The counter clears on fifo_clr.
  - err_in_fifo = (counter ≠ 0).
- Timeout counter (10 bits):
  - Cleared on accepted push, accepted pop, fifo_clr, or while empty.
  - Otherwise increments on baud_tick and saturates at limit = 64*char_bits (4 character times x 16 ticks).
  - timeout_irq = !empty && (counter == limit).
  - timeout_irq deasserts the cycle after the next accepted pop or push.
- Wrap-around: pointers are $clog2(DEPTH) bits, wrap naturally; full/empty come from count, not pointer compare.

Decomposition:
- uart_pkg holds:
  - typedef trig_sel_t (enum TRIG_1, TRIG_4, TRIG_8, TRIG_14 = 2'b00..2'b11);
  - function trig_threshold(trig_sel_t) returning 0/3/7/13;
  - localparam TOUT_CHARS=4 and OVERSAMPLE=16;
  - typedef rx_err_t {brk, fe, pe}.
- One sub-module, uart_sync_fifo, holds storage, pointers and count. It has the same clk/rst, push/pop/clr, and a show-ahead read.
- Thresholds, timeout and error counting stay in uart_rx_fifo_ctrl.

Test Plan:
- trig_sel=01; push 0x11,0x22,0x33 → rda_irq=0. Push 0x44 → rda_irq=1 with count=4. Pop once → rda_irq=0, rd_data=0x22.
- Push 16 chars 0x00..0x0F, then push 0xAA → overrun pulses 1 cycle, count=16. Pop 16 times → rd_data sequence is 0x00..0x0F; 0xAA never appears.
- Full FIFO, same-cycle push 0x55 and pop → no overrun, count stays 16. After 16 pops the last rd_data=0x55 (wrap-around verified).
- Push 0x41 with push_err=3'b010, then push 0x42 clean → err_in_fifo=1. Pop once → err_in_fifo=0.
- char_bits=10; push 1 char, drive baud_tick every 4 clk → timeout_irq=1 after exactly 640 ticks (2560 clk). Pop → timeout_irq=0, empty=1.
- Fill 5 chars, assert fifo_clr together with push → count=0, empty=1, rda_irq=0, err_in_fifo=0. Assert rst mid-fill → all outputs at reset values the next cycle.
